ddr2_idelay_rst_seq: RTL and testbench

- Drives the reset of the IDELAYCTRL wrapper and consumes its rdy_status, so it sits at the opposite end of that reset/ready handshake.
- Holds the IDELAYCTRL bank in reset for a fixed minimum time, then waits for ready with a timeout and retries on failure.
- Once locked, it filters glitches on ready and relocks on genuine loss.
- Sits in the clk200 domain between the PHY reset logic and DDR2 calibration; calibration starts only when idelay_ready is high.

---
 rtl/ddr2_idelay_rst_seq.sv | 81 ++++++++
 tb/tb_ddr2_idelay_rst_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ddr2_idelay_rst_seq.sv
// ddr2_idelay_rst_seq: IDELAYCTRL reset/ready sequencer with timeout retry and lock-loss filtering
module ddr2_idelay_rst_seq #(
  parameter int RST_CYCLES  = 16,
  parameter int RDY_TIMEOUT = 1024,
  parameter int DROP_FILT   = 4,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk200,
  input  logic       reset,
  input  logic       rdy_status,
  output logic       idelay_rst,
  output logic       idelay_ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic [1:0] state
);
  localparam int CW = $clog2(RST_CYCLES > RDY_TIMEOUT ? RST_CYCLES : RDY_TIMEOUT);
  localparam logic [1:0] ST_HOLD = 2'd0, ST_WAIT = 2'd1, ST_LOCKED = 2'd2, ST_FAIL = 2'd3;
  logic [CW-1:0] cnt;
  logic [3:0] drop;
  logic [1:0] sync;
  logic rdy_s;
  assign rdy_s = sync[1];
  always_ff @(posedge clk200) begin
    if (reset) begin
      state        <= ST_HOLD;
      idelay_rst   <= 1'b1;
      idelay_ready <= 1'b0;
      fail         <= 1'b0;
      lock_lost    <= 1'b0;
      retry_cnt    <= '0;
      cnt          <= '0;
      drop         <= '0;
      sync         <= '0;
    end else begin
      sync <= {sync[0], rdy_status};
      case (state)
        ST_HOLD:
          if (cnt == CW'(RST_CYCLES - 1)) begin
            state      <= ST_WAIT;
            idelay_rst <= 1'b0;
            cnt        <= '0;
          end else cnt <= cnt + 1'b1;
        ST_WAIT:
          if (rdy_s) begin
            state        <= ST_LOCKED;
            idelay_ready <= 1'b1;
            drop         <= '0;
            cnt          <= '0;
          end else if (cnt == CW'(RDY_TIMEOUT - 1)) begin
            if (retry_cnt == 4'(MAX_RETRY)) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end else begin
              state      <= ST_HOLD;
              idelay_rst <= 1'b1;
              retry_cnt  <= retry_cnt + 1'b1;
              cnt        <= '0;
            end
          end else cnt <= cnt + 1'b1;
        ST_LOCKED:
          if (rdy_s) drop <= '0;
          else if (drop == 4'(DROP_FILT - 1)) begin
            state        <= ST_HOLD;
            idelay_ready <= 1'b0;
            idelay_rst   <= 1'b1;
            lock_lost    <= 1'b1;
            retry_cnt    <= '0;
            cnt          <= '0;
            drop         <= '0;
          end else drop <= drop + 1'b1;
        default: begin
          idelay_rst   <= 1'b0;
          idelay_ready <= 1'b0;
          fail         <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ddr2_idelay_rst_seq.sv
// tb_ddr2_idelay_rst_seq: directed and randomized checks of the sequencer against a cycle-level reference model
module tb_ddr2_idelay_rst_seq;
  localparam int RST = 16, TO = 1024, DF = 4, MR = 3;
  logic clk200 = 1'b0, reset = 1'b1, rdy_status = 1'b0;
  logic idelay_rst, idelay_ready, fail, lock_lost;
  logic [3:0] retry_cnt;
  logic [1:0] state;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_ph = 0, m_t = 0, m_low = 0, m_retry = 0;
  bit m_lost = 0;
  bit m_q [2];
  ddr2_idelay_rst_seq #(.RST_CYCLES(RST), .RDY_TIMEOUT(TO), .DROP_FILT(DF), .MAX_RETRY(MR)) dut (
    .clk200(clk200), .reset(reset), .rdy_status(rdy_status), .idelay_rst(idelay_rst),
    .idelay_ready(idelay_ready), .fail(fail), .lock_lost(lock_lost), .retry_cnt(retry_cnt), .state(state)
  );
  always #5 clk200 = ~clk200;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic model_step(input logic r, input logic x);
    bit rs;
    if (r) begin
      m_ph = 0; m_t = 0; m_low = 0; m_retry = 0; m_lost = 0; m_q[0] = 0; m_q[1] = 0;
      return;
    end
    rs = m_q[1];
    m_q[1] = m_q[0];
    m_q[0] = x;
    case (m_ph)
      0: begin
        m_t++;
        if (m_t == RST) begin m_ph = 1; m_t = 0; end
      end
      1: if (rs) begin m_ph = 2; m_low = 0; end
         else if (m_t + 1 == TO) begin
           if (m_retry == MR) m_ph = 3;
           else begin m_retry++; m_ph = 0; m_t = 0; end
         end else m_t++;
      2: begin
        m_low = rs ? 0 : m_low + 1;
        if (m_low == DF) begin m_ph = 0; m_lost = 1; m_retry = 0; m_t = 0; m_low = 0; end
      end
      default: ;
    endcase
  endtask
  function automatic logic [9:0] outs();
    return {idelay_rst, idelay_ready, fail, lock_lost, retry_cnt, state};
  endfunction
  function automatic logic [9:0] model_outs();
    return {m_ph == 0, m_ph == 2, m_ph == 3, m_lost, 4'(m_retry), 2'(m_ph)};
  endfunction
  task automatic tick();
    @(posedge clk200);
    model_step(reset, rdy_status);
    #1;
    cyc++;
    chk("model", 32'(outs()), 32'(model_outs()));
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("reset_vals", 32'(outs()), 32'h200);
    reset = 1'b0;
    cyc = 0;
  endtask
  task automatic run_to(input int c, input logic v);
    while (cyc < c) begin
      rdy_status = v;
      tick();
    end
  endtask
  initial begin
    int lo, rr, nh, run;
    int hold_at [3];
    int hold_rc [3];
    logic lvl;
    logic [1:0] prev;
    // 1: ready arrives at cycle 30
    rdy_status = 1'b0;
    do_reset();
    lo = -1; rr = -1;
    while (cyc < 40) begin
      rdy_status = (cyc >= 30);
      tick();
      if (!idelay_rst && lo < 0) lo = cyc;
      if (idelay_ready && rr < 0) rr = cyc;
    end
    chk("t1_rst_low_cycle", 32'(lo), 32'd16);
    chk("t1_ready_cycle", 32'(rr), 32'd33);
    chk("t1_retry_fail", 32'({retry_cnt, fail}), 32'd0);
    // 3: glitch filtering and relock
    for (int i = 0; i < 3; i++) begin rdy_status = 1'b0; tick(); end
    for (int i = 0; i < 8; i++) begin rdy_status = 1'b1; tick(); end
    chk("t3_short_glitch", 32'({idelay_ready, lock_lost}), 32'b10);
    for (int i = 0; i < 4; i++) begin rdy_status = 1'b0; tick(); end
    for (int i = 0; i < 4; i++) begin rdy_status = 1'b1; tick(); end
    chk("t3_lock_loss", 32'({idelay_ready, idelay_rst, lock_lost, retry_cnt}), 32'b1_1_0000 | 32'h0);
    rr = 0;
    while (!idelay_ready && rr < 200) begin rdy_status = 1'b1; tick(); rr++; end
    chk("t3_relock", 32'({idelay_ready, lock_lost}), 32'b11);
    // 4: ready high from reset is ignored in hold
    rdy_status = 1'b1;
    do_reset();
    rr = -1;
    while (cyc < 30) begin
      tick();
      if (idelay_ready && rr < 0) rr = cyc;
    end
    chk("t4_ready_cycle", 32'(rr), 32'd17);
    // 2: timeouts, retries and fail
    rdy_status = 1'b0;
    do_reset();
    nh = 0; lo = -1; prev = state;
    while (cyc < 4200) begin
      tick();
      if (state == 2'd0 && prev == 2'd1 && nh < 3) begin hold_at[nh] = cyc; hold_rc[nh] = retry_cnt; nh++; end
      if (fail && lo < 0) lo = cyc;
      prev = state;
    end
    chk("t2_retries_seen", 32'(nh), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_cycle", 32'(hold_at[i]), 32'(1040 * (i + 1)));
      chk("t2_hold_retry", 32'(hold_rc[i]), 32'(i + 1));
    end
    chk("t2_fail_cycle", 32'(lo), 32'd4160);
    chk("t2_fail_outs", 32'({idelay_rst, idelay_ready, fail, state}), 32'b00111);
    // 6: reset mid-fail and mid-wait
    do_reset();
    run_to(500, 1'b0);
    do_reset();
    lo = 0;
    while (cyc < 40) begin
      tick();
      if (idelay_rst) lo++;
    end
    chk("t6_rst_len", 32'(lo + 1), 32'd16);
    // 5: synchronized ready coincides with the timeout count
    do_reset();
    run_to(1037, 1'b0);
    rr = -1;
    while (cyc < 1060) begin
      rdy_status = 1'b1;
      tick();
      if (idelay_ready && rr < 0) rr = cyc;
    end
    chk("t5_ready_cycle", 32'(rr), 32'd1040);
    chk("t5_retry", 32'({retry_cnt, state}), 32'b0000_10);
    // randomized runs with glitches, long gaps and occasional resets
    for (int t = 0; t < 8; t++) begin
      do_reset();
      run = 0;
      lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if (run == 0) begin
          lvl = 1'($urandom_range(0, 1));
          run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1200) : $urandom_range(1, 6);
        end
        run--;
        rdy_status = lvl;
        reset = ($urandom_range(0, 1999) == 0);
        tick();
      end
      reset = 1'b0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
